countdown_timer: RTL and testbench
==================================

Name: countdown_timer

Overview:
- Loadable down-counter, the consuming counterpart of the team's incrementing event counter: software or an FSM loads a count, and the block decrements it on qualified `decr` strobes.
- Sequenced by a small run/hold/done FSM with a prescaler; flags expiry with a one-cycle `done` pulse.
- Used for timeouts, frame/byte budgets and delay generation beside the existing counters on the same clock domain.

Parameters:
- W, 8, width of count value and `q`.
- PRESCALE, 1, number of qualified `decr` strobes per decrement of `q`; legal range 1..256.
- AUTO_RELOAD, 0, 1 = on expiry reload the last loaded value and keep running; 0 = stop in DONE.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-low: the block is in reset while rst = 0.
- load  input  1  capture `load_val` into `q` and the reload register.
- load_val  input  W  value captured on `load`.
- start  input  1  begin or resume counting.
- pause  input  1  suspend counting (RUN -> HOLD).
- decr  input  1  count-qualify strobe; ignored outside RUN.
- q  output  W  current count (registered).
- busy  output  1  high in RUN or HOLD.
- done  output  1  one-cycle expiry pulse (registered).

Behaviour:
- Reset (rst = 0, asynchronous): q = 0, reload register = 0, prescaler = 0, state = IDLE, busy = 0, done = 0. Recovery is synchronous to clk.
- States: IDLE, RUN, HOLD, DONE. `busy` is decoded from state; `done` is a separate register.
- Priority each cycle: load > pause > start > decr.
- load, in any state:
  - q <= load_val; reload <= load_val; prescaler <= 0; state <= IDLE; done <= 0.
  - start, pause and decr are ignored that cycle.
- IDLE:
  - start with q != 0 -> RUN.
  - start with q == 0 -> DONE, with done = 1 in the next cycle.
  - pause and decr have no effect.
- RUN:
  - pause -> HOLD; no prescaler or q change that cycle, even if decr = 1.
  - decr and prescaler < PRESCALE-1 -> prescaler + 1.
  - decr and prescaler == PRESCALE-1 -> prescaler <= 0 and q <= q - 1.
  - With PRESCALE = 1, every decr decrements q.
- Expiry: the decrement that takes q from 1 to 0 also sets done = 1 in the same cycle in which q reads 0.
  - AUTO_RELOAD = 0: state -> DONE.
  - AUTO_RELOAD = 1, reload != 0: q <= reload instead of 0, stay in RUN, done still pulses.
  - AUTO_RELOAD = 1, reload == 0: behave as AUTO_RELOAD = 0.
- HOLD: start -> RUN with the prescaler value retained; decr is ignored.
- DONE:
  - q holds 0; start, pause and decr are ignored; only load or reset exits.
- done is high for exactly one cycle per expiry and never asserted two cycles back-to-back.
- No wrap-around: q never decrements below 0.
- Reset mid-count aborts immediately; no done pulse.
- Arithmetic is unsigned W-bit. The prescaler is max(1,$clog2(PRESCALE)) bits wide and is compared against PRESCALE-1.

Decomposition:
- Shared package `timer_pkg`: state enum (IDLE, RUN, HOLD, DONE), with 2-bit encoding fixed for debug visibility.
- Natural sub-module `prescaler_div`:
  - inputs clk, rst, clr, en;
  - output `tick` = en & (cnt == PRESCALE-1);
  - parameter PRESCALE.
- The top level holds the FSM, `q`, the reload register and `done`.

Test Plan:
- Reset: hold rst = 0 mid-RUN with q = 5 -> q = 0, busy = 0, done = 0 asynchronously; with no load after release, start goes IDLE -> DONE and done pulses once.
- Basic countdown, PRESCALE = 1: load 3, start, decr high continuously -> q = 2, 1, 0 on successive cycles; done = 1 exactly in the cycle q = 0; busy drops; further decr leaves q = 0.
- Prescale, PRESCALE = 4: load 2, start, 8 decr strobes interleaved with idle cycles -> q changes only on the 4th and 8th strobe; a single done pulse.
- Pause/resume: load 10, start, 5 decr -> q = 5; pause together with decr -> q stays 5, busy = 1; start -> 5 more decr -> q = 0, done pulse.
- Auto-reload, AUTO_RELOAD = 1: load 2, start, 6 decr -> q sequence 1, 2, 1, 2, 1, 2 with done pulsing at each 1 -> 0 transition (3 pulses); busy stays 1.
- Simultaneous events: load 7 with start = 1 and decr = 1 in the same cycle -> q = 7, state IDLE; start while q = 0 in IDLE -> DONE, done = 1 for one cycle.

Source files
------------

// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared state encoding and sizing helper for countdown_timer
package timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    function automatic int prescale_width(input int p);
        return ($clog2(p) < 1) ? 1 : $clog2(p);
    endfunction

endpackage

// File: rtl/prescaler_div.sv
// rtl/prescaler_div.sv - divides qualified strobes by PRESCALE, emitting a tick on the last one
module prescaler_div
    import timer_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int            PW   = prescale_width(PRESCALE);
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] cnt;

    assign tick = en & (cnt == LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + PW'(1);
        end
    end

endmodule

// File: rtl/countdown_timer.sv
// rtl/countdown_timer.sv - loadable down-counter with run/hold/done sequencing and prescaled decrement
module countdown_timer
    import timer_pkg::*;
#(
    parameter int W           = 8,
    parameter int PRESCALE    = 1,
    parameter int AUTO_RELOAD = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         start,
    input  logic         pause,
    input  logic         decr,
    output logic [W-1:0] q,
    output logic         busy,
    output logic         done
);

    state_t       state, state_nxt;
    logic [W-1:0] reload;
    logic         run_en;
    logic         tick;
    logic         expire;
    logic         reload_ok;
    logic         start_go;
    logic         start_zero;

    // Higher-priority load/pause block the strobe before it reaches the divider.
    assign run_en     = (state == ST_RUN) & decr & ~pause & ~load;
    assign expire     = tick & (q == W'(1));
    assign reload_ok  = (AUTO_RELOAD != 0) && (reload != '0);
    assign start_go   = ~load & ~pause & start;
    assign start_zero = (state == ST_IDLE) & start_go & (q == '0);
    assign busy       = (state == ST_RUN) || (state == ST_HOLD);

    prescaler_div #(
        .PRESCALE(PRESCALE)
    ) u_div (
        .clk  (clk),
        .rst  (rst),
        .clr  (load),
        .en   (run_en),
        .tick (tick)
    );

    always_comb begin
        state_nxt = state;
        if (load) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (start_go) state_nxt = (q == '0) ? ST_DONE : ST_RUN;
                ST_RUN: begin
                    if (pause)                       state_nxt = ST_HOLD;
                    else if (expire && !reload_ok)   state_nxt = ST_DONE;
                end
                ST_HOLD: if (start_go) state_nxt = ST_RUN;
                default: state_nxt = state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q      <= '0;
            reload <= '0;
            done   <= 1'b0;
        end else if (load) begin
            q      <= load_val;
            reload <= load_val;
            done   <= 1'b0;
        end else begin
            // A reload of 1 could expire every cycle; the pulse is kept isolated.
            done <= (expire | start_zero) & ~done;
            if (tick && q != '0) begin
                q <= (expire && reload_ok) ? reload : q - W'(1);
            end
        end
    end

endmodule

// File: tb/tb_countdown_timer.sv
// tb/tb_countdown_timer.sv - scoreboard bench for countdown_timer across three parameter sets
module tb_countdown_timer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       load = 1'b0, start = 1'b0, pause = 1'b0, decr = 1'b0;
    logic [7:0] load_val = 8'd0;
    logic [7:0] q0, q1, q2;
    logic       b0, b1, b2, d0, d1, d2;

    typedef struct {
        int         sel;
        logic [7:0] q;
        logic       busy;
        logic       done;
        string      tag;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    int pd[13] = '{1, 0, 1, 0, 1, 1, 0, 1, 1, 1, 0, 1, 0};
    int pq[13] = '{2, 2, 2, 2, 2, 1, 1, 1, 1, 1, 1, 0, 0};
    int pb[13] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0};
    int pn[13] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};

    always #5 clk = ~clk;

    countdown_timer #(.W(8), .PRESCALE(1), .AUTO_RELOAD(0)) u0 (
        .clk(clk), .rst(rst), .load(load), .load_val(load_val), .start(start),
        .pause(pause), .decr(decr), .q(q0), .busy(b0), .done(d0));

    countdown_timer #(.W(8), .PRESCALE(4), .AUTO_RELOAD(0)) u1 (
        .clk(clk), .rst(rst), .load(load), .load_val(load_val), .start(start),
        .pause(pause), .decr(decr), .q(q1), .busy(b1), .done(d1));

    countdown_timer #(.W(8), .PRESCALE(1), .AUTO_RELOAD(1)) u2 (
        .clk(clk), .rst(rst), .load(load), .load_val(load_val), .start(start),
        .pause(pause), .decr(decr), .q(q2), .busy(b2), .done(d2));

    function automatic logic [9:0] dut_out(input int sel);
        case (sel)
            0:       return {q0, b0, d0};
            1:       return {q1, b1, d1};
            default: return {q2, b2, d2};
        endcase
    endfunction

    task automatic chk(input string tag, input int sel, input logic [9:0] act, input logic [9:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s dut%0d got q=%0d busy=%0b done=%0b want q=%0d busy=%0b done=%0b",
                     tag, sel, act[9:2], act[1], act[0], want[9:2], want[1], want[0]);
        end
    endtask

    task automatic drive(input logic l, input logic [7:0] v, input logic s, input logic p, input logic d);
        @(negedge clk);
        load = l; load_val = v; start = s; pause = p; decr = d;
    endtask

    task automatic ex(input int sel, input int qv, input int bv, input int dv, input string tag);
        exp_t e;
        e.sel = sel; e.q = 8'(qv); e.busy = (bv != 0); e.done = (dv != 0); e.tag = tag;
        sb.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            while (sb.size() > 0) begin
                e = sb.pop_front();
                chk(e.tag, e.sel, dut_out(e.sel), {e.q, e.busy, e.done});
            end
        end
    end

    initial begin : stim
        #1;
        for (int s = 0; s < 3; s++) chk("reset_state", s, dut_out(s), 10'd0);
        @(negedge clk);
        rst = 1'b1;

        drive(1, 8'd3, 0, 0, 0); ex(0, 3, 0, 0, "basic_load");
        drive(0, 8'd0, 1, 0, 0); ex(0, 3, 1, 0, "basic_start");
        drive(0, 8'd0, 0, 0, 1); ex(0, 2, 1, 0, "basic_q2");
        drive(0, 8'd0, 0, 0, 1); ex(0, 1, 1, 0, "basic_q1");
        drive(0, 8'd0, 0, 0, 1); ex(0, 0, 0, 1, "basic_expire");
        drive(0, 8'd0, 0, 0, 1); ex(0, 0, 0, 0, "basic_nowrap");
        drive(0, 8'd0, 1, 1, 1); ex(0, 0, 0, 0, "basic_done_sticky");

        drive(1, 8'd2, 0, 0, 0); ex(1, 2, 0, 0, "pre_load");
        drive(0, 8'd0, 1, 0, 0); ex(1, 2, 1, 0, "pre_start");
        for (int i = 0; i < 13; i++) begin
            drive(0, 8'd0, 0, 0, pd[i] != 0);
            ex(1, pq[i], pb[i], pn[i], $sformatf("pre_step%0d", i));
        end

        drive(1, 8'd10, 0, 0, 0); ex(0, 10, 0, 0, "pause_load"); ex(1, 10, 0, 0, "pause_load");
        drive(0, 8'd0, 1, 0, 0);  ex(0, 10, 1, 0, "pause_start"); ex(1, 10, 1, 0, "pause_start");
        for (int i = 0; i < 5; i++) begin
            drive(0, 8'd0, 0, 0, 1);
            ex(0, 9 - i, 1, 0, $sformatf("pause_run%0d", i));
            ex(1, (i < 3) ? 10 : 9, 1, 0, $sformatf("pause_run%0d", i));
        end
        drive(0, 8'd0, 0, 1, 1); ex(0, 5, 1, 0, "pause_hold"); ex(1, 9, 1, 0, "pause_hold");
        drive(0, 8'd0, 0, 0, 1); ex(0, 5, 1, 0, "hold_decr"); ex(1, 9, 1, 0, "hold_decr");
        drive(0, 8'd0, 1, 0, 0); ex(0, 5, 1, 0, "resume"); ex(1, 9, 1, 0, "resume");
        for (int i = 0; i < 5; i++) begin
            drive(0, 8'd0, 0, 0, 1);
            ex(0, 4 - i, (i < 4) ? 1 : 0, (i == 4) ? 1 : 0, $sformatf("resume_run%0d", i));
            ex(1, (i < 2) ? 9 : 8, 1, 0, $sformatf("resume_run%0d", i));
        end

        drive(1, 8'd2, 0, 0, 0); ex(2, 2, 0, 0, "ar_load");
        drive(0, 8'd0, 1, 0, 0); ex(2, 2, 1, 0, "ar_start");
        for (int i = 0; i < 6; i++) begin
            drive(0, 8'd0, 0, 0, 1);
            ex(2, (i % 2 == 0) ? 1 : 2, 1, i % 2, $sformatf("ar_run%0d", i));
        end
        drive(0, 8'd0, 0, 0, 0); ex(2, 2, 1, 0, "ar_idle");

        drive(1, 8'd7, 1, 0, 1); ex(0, 7, 0, 0, "sim_load_wins");
        drive(0, 8'd0, 0, 0, 0); ex(0, 7, 0, 0, "sim_stays_idle");
        drive(1, 8'd0, 0, 0, 0); ex(0, 0, 0, 0, "zero_load");
        drive(0, 8'd0, 1, 0, 0); ex(0, 0, 0, 1, "zero_start_done");
        drive(0, 8'd0, 0, 0, 0); ex(0, 0, 0, 0, "zero_pulse_once");
        drive(0, 8'd0, 1, 1, 1); ex(0, 0, 0, 0, "zero_done_sticky");

        drive(1, 8'd5, 0, 0, 0); ex(0, 5, 0, 0, "rst_load");
        drive(0, 8'd0, 1, 0, 0); ex(0, 5, 1, 0, "rst_running");
        @(posedge clk);
        #3;
        start = 1'b0; load = 1'b0; pause = 1'b0; decr = 1'b0;
        rst = 1'b0;
        #1;
        chk("rst_async", 0, dut_out(0), 10'd0);
        chk("rst_async", 2, dut_out(2), 10'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        drive(0, 8'd0, 1, 0, 0); ex(0, 0, 0, 1, "post_rst_start");
        drive(0, 8'd0, 0, 0, 0); ex(0, 0, 0, 0, "post_rst_idle");

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() > 0) begin
            failures++;
            $display("FAIL drain pending=%0d want 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
